tdm_demux32: RTL and testbench

- Time-division demultiplexer: the receive end of the 32:1 lane-select path.
- Accepts a serialized stream of one N-bit sample per valid beat, framed by a start-of-frame marker.
- Deposits beat k of a frame into lane k and presents all 32 lanes in parallel.
- Outputs update atomically per completed frame through a shadow bank, so downstream logic never sees a partial frame.

---
 rtl/tdm_demux32_if.sv | 37 +++
 rtl/tdm_demux32.sv | 99 +++++++++
 tb/tb_tdm_demux32.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux32_if.sv
// Bundle of the stream input and parallel lane outputs of the 32-lane TDM demultiplexer.
// The master modport is the stream source and lane consumer; the slave modport is the demux itself.
interface tdm_demux32_if #(
  parameter int N = 1
);
  logic         ena;
  logic         in_valid;
  logic         in_sof;
  logic [N-1:0] in_data;

  logic [N-1:0] out00, out01, out02, out03, out04, out05, out06, out07;
  logic [N-1:0] out08, out09, out10, out11, out12, out13, out14, out15;
  logic [N-1:0] out16, out17, out18, out19, out20, out21, out22, out23;
  logic [N-1:0] out24, out25, out26, out27, out28, out29, out30, out31;

  logic         frame_valid;
  logic         frame_error;
  logic [4:0]   lane;

  modport master (
    output ena, in_valid, in_sof, in_data,
    input  out00, out01, out02, out03, out04, out05, out06, out07,
    input  out08, out09, out10, out11, out12, out13, out14, out15,
    input  out16, out17, out18, out19, out20, out21, out22, out23,
    input  out24, out25, out26, out27, out28, out29, out30, out31,
    input  frame_valid, frame_error, lane
  );

  modport slave (
    input  ena, in_valid, in_sof, in_data,
    output out00, out01, out02, out03, out04, out05, out06, out07,
    output out08, out09, out10, out11, out12, out13, out14, out15,
    output out16, out17, out18, out19, out20, out21, out22, out23,
    output out24, out25, out26, out27, out28, out29, out30, out31,
    output frame_valid, frame_error, lane
  );
endinterface

// File: rtl/tdm_demux32.sv
// Receive end of the 32:1 TDM path: collects one sample per beat into a shadow bank and
// publishes all 32 lanes at once when beat 31 arrives, so consumers never see a partial frame.
module tdm_demux32 #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux32_if.slave bus
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t       state_q;
  logic [4:0]   lane_q;
  logic [N-1:0] shadow_q [31];
  logic [N-1:0] out_q    [32];
  logic         frameValid_q;
  logic         frameError_q;
  logic         beat;

  assign beat = bus.ena && bus.in_valid;

  // Single FSM: pulses default low on every edge (including ena=0 edges), a sof beat always
  // restarts at lane 0, and the final beat is written straight to out31 while the rest come
  // from the shadow bank, so the whole frame lands on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_q       <= 5'd0;
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      for (int i = 0; i < 31; i++) shadow_q[i] <= '0;
      for (int i = 0; i < 32; i++) out_q[i] <= '0;
    end else begin
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      if (beat) begin
        if (bus.in_sof) begin
          if (state_q == FILL) frameError_q <= 1'b1;
          shadow_q[0] <= bus.in_data;
          lane_q      <= 5'd1;
          state_q     <= FILL;
        end else if (state_q == FILL) begin
          if (lane_q == 5'd31) begin
            for (int i = 0; i < 31; i++) out_q[i] <= shadow_q[i];
            out_q[31]    <= bus.in_data;
            frameValid_q <= 1'b1;
            lane_q       <= 5'd0;
            state_q      <= IDLE;
          end else begin
            shadow_q[lane_q] <= bus.in_data;
            lane_q           <= lane_q + 5'd1;
          end
        end
      end
    end
  end

  assign bus.frame_valid = frameValid_q;
  assign bus.frame_error = frameError_q;
  assign bus.lane        = lane_q;

  assign bus.out00 = out_q[0];
  assign bus.out01 = out_q[1];
  assign bus.out02 = out_q[2];
  assign bus.out03 = out_q[3];
  assign bus.out04 = out_q[4];
  assign bus.out05 = out_q[5];
  assign bus.out06 = out_q[6];
  assign bus.out07 = out_q[7];
  assign bus.out08 = out_q[8];
  assign bus.out09 = out_q[9];
  assign bus.out10 = out_q[10];
  assign bus.out11 = out_q[11];
  assign bus.out12 = out_q[12];
  assign bus.out13 = out_q[13];
  assign bus.out14 = out_q[14];
  assign bus.out15 = out_q[15];
  assign bus.out16 = out_q[16];
  assign bus.out17 = out_q[17];
  assign bus.out18 = out_q[18];
  assign bus.out19 = out_q[19];
  assign bus.out20 = out_q[20];
  assign bus.out21 = out_q[21];
  assign bus.out22 = out_q[22];
  assign bus.out23 = out_q[23];
  assign bus.out24 = out_q[24];
  assign bus.out25 = out_q[25];
  assign bus.out26 = out_q[26];
  assign bus.out27 = out_q[27];
  assign bus.out28 = out_q[28];
  assign bus.out29 = out_q[29];
  assign bus.out30 = out_q[30];
  assign bus.out31 = out_q[31];

endmodule

// File: tb/tb_tdm_demux32.sv
// Bench for tdm_demux32 (N=8): directed frames checked every cycle against a queue-based
// frame model, plus literal expectations that pin the model itself.
module tb_tdm_demux32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tdm_demux32_if #(.N(8)) bus ();

  tdm_demux32 #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] outs [32];
  assign outs[0]  = bus.out00;
  assign outs[1]  = bus.out01;
  assign outs[2]  = bus.out02;
  assign outs[3]  = bus.out03;
  assign outs[4]  = bus.out04;
  assign outs[5]  = bus.out05;
  assign outs[6]  = bus.out06;
  assign outs[7]  = bus.out07;
  assign outs[8]  = bus.out08;
  assign outs[9]  = bus.out09;
  assign outs[10] = bus.out10;
  assign outs[11] = bus.out11;
  assign outs[12] = bus.out12;
  assign outs[13] = bus.out13;
  assign outs[14] = bus.out14;
  assign outs[15] = bus.out15;
  assign outs[16] = bus.out16;
  assign outs[17] = bus.out17;
  assign outs[18] = bus.out18;
  assign outs[19] = bus.out19;
  assign outs[20] = bus.out20;
  assign outs[21] = bus.out21;
  assign outs[22] = bus.out22;
  assign outs[23] = bus.out23;
  assign outs[24] = bus.out24;
  assign outs[25] = bus.out25;
  assign outs[26] = bus.out26;
  assign outs[27] = bus.out27;
  assign outs[28] = bus.out28;
  assign outs[29] = bus.out29;
  assign outs[30] = bus.out30;
  assign outs[31] = bus.out31;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Frame model: samples of the frame in progress are kept in a queue; a frame is published
  // when the queue reaches 32 samples, and a sof while collecting throws the queue away.
  logic [7:0] collected [$];
  logic [7:0] expOut [32];
  bit         expValid = 1'b0;
  bit         expError = 1'b0;
  int         cycleCnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      collected.delete();
      for (int i = 0; i < 32; i++) expOut[i] = 8'h00;
      expValid = 1'b0;
      expError = 1'b0;
    end else begin
      cycleCnt++;
      expValid = 1'b0;
      expError = 1'b0;
      if (bus.ena && bus.in_valid) begin
        if (bus.in_sof) begin
          if (collected.size() != 0) expError = 1'b1;
          collected.delete();
          collected.push_back(bus.in_data);
        end else if (collected.size() != 0) begin
          collected.push_back(bus.in_data);
          if (collected.size() == 32) begin
            for (int i = 0; i < 32; i++) expOut[i] = collected[i];
            collected.delete();
            expValid = 1'b1;
          end
        end
      end
    end
  end

  int validSeen = 0;
  int errorSeen = 0;
  int lastValidCycle = 0;
  int validGap = 0;

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("lane", {27'd0, bus.lane}, collected.size());
      checkOutput("frame_valid", {31'd0, bus.frame_valid}, {31'd0, expValid});
      checkOutput("frame_error", {31'd0, bus.frame_error}, {31'd0, expError});
      checkOutput("pulse_exclusive", {31'd0, bus.frame_valid & bus.frame_error}, 32'd0);
      for (int i = 0; i < 32; i++)
        checkOutput($sformatf("out%02d", i), {24'd0, outs[i]}, {24'd0, expOut[i]});
      if (bus.frame_valid) begin
        validGap = cycleCnt - lastValidCycle;
        lastValidCycle = cycleCnt;
        validSeen++;
      end
      if (bus.frame_error) errorSeen++;
    end
  end

  // Drives one clock's worth of inputs, then returns just after the sampling edge.
  task automatic applyStimulus(input logic e, input logic v, input logic s, input logic [7:0] d);
    bus.ena      = e;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] base, input bit gaps);
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b1, 1'b1, k == 0, base + 8'(k));
      if (gaps && k < 31) applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
    end
  endtask

  int errBefore;
  int validBefore;

  initial begin
    bus.ena = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = 8'h00;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_out00", {24'd0, bus.out00}, 32'h00);
    checkOutput("reset_out31", {24'd0, bus.out31}, 32'h00);
    checkOutput("reset_lane", {27'd0, bus.lane}, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.frame_valid}, 32'd0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full frame, no gaps
    $display("[TB] test 1: full frame");
    sendFrame(8'h10, 1'b0);
    checkOutput("t1_out00", {24'd0, bus.out00}, 32'h10);
    checkOutput("t1_out15", {24'd0, bus.out15}, 32'h1F);
    checkOutput("t1_out31", {24'd0, bus.out31}, 32'h2F);
    checkOutput("t1_valid_now", {31'd0, bus.frame_valid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_valid_count", validSeen, 32'd1);
    checkOutput("t1_error_count", errorSeen, 32'd0);

    // 2: gaps every other cycle and a 5-cycle enable drop mid-frame
    $display("[TB] test 2: gaps and enable");
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b1, 1'b1, k == 0, 8'h10 + 8'(k));
      if (k == 10) begin
        for (int j = 0; j < 5; j++) begin
          applyStimulus(1'b0, 1'b1, j[0], 8'hFF);
          checkOutput("t2_lane_hold", {27'd0, bus.lane}, 32'd11);
        end
      end
      if (k < 31) applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
    end
    checkOutput("t2_out15", {24'd0, bus.out15}, 32'h1F);
    checkOutput("t2_out31", {24'd0, bus.out31}, 32'h2F);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_valid_count", validSeen, 32'd2);

    // 3: short frame interrupted by sof at lane 10
    $display("[TB] test 3: short frame");
    sendFrame(8'hA0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, k == 0, 8'hB0 + 8'(k));
    checkOutput("t3_lane10", {27'd0, bus.lane}, 32'd10);
    errBefore = errorSeen;
    sendFrame(8'hC0, 1'b0);
    checkOutput("t3_out00", {24'd0, bus.out00}, 32'hC0);
    checkOutput("t3_out31", {24'd0, bus.out31}, 32'hDF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("t3_error_once", errorSeen - errBefore, 32'd1);

    // 4: reset in the middle of a frame takes effect without a clock edge
    $display("[TB] test 4: reset mid-frame");
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1, k == 0, 8'h70 + 8'(k));
    checkOutput("t4_lane20", {27'd0, bus.lane}, 32'd20);
    rst = 1'b1;
    #1;
    checkOutput("t4_out00_zero", {24'd0, bus.out00}, 32'h00);
    checkOutput("t4_out31_zero", {24'd0, bus.out31}, 32'h00);
    checkOutput("t4_lane_zero", {27'd0, bus.lane}, 32'd0);
    #1 rst = 1'b0;
    sendFrame(8'h40, 1'b0);
    checkOutput("t4_out00", {24'd0, bus.out00}, 32'h40);
    checkOutput("t4_out31", {24'd0, bus.out31}, 32'h5F);

    // 5: stray data in IDLE, then back-to-back frames
    $display("[TB] test 5: stray data and back-to-back");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    checkOutput("t5_lane_idle", {27'd0, bus.lane}, 32'd0);
    checkOutput("t5_out31_kept", {24'd0, bus.out31}, 32'h5F);
    validBefore = validSeen;
    sendFrame(8'h60, 1'b0);
    checkOutput("t5_out31_first", {24'd0, bus.out31}, 32'h7F);
    sendFrame(8'h80, 1'b0);
    checkOutput("t5_out00_second", {24'd0, bus.out00}, 32'h80);
    checkOutput("t5_out31_second", {24'd0, bus.out31}, 32'h9F);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("t5_valid_count", validSeen - validBefore, 32'd2);
    checkOutput("t5_valid_spacing", validGap, 32'd32);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
